// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants, types and helpers.
package ldpc_pkg;

  localparam int unsigned ROW_NUMBER = 512;
  localparam int unsigned ROW_WEIGHT = 6;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_W     = 20;

  // Width of an index counting 0..n-1; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_W = idx_w(ROW_NUMBER);

  // Row-boundary tags that travel with every message (default geometry).
  typedef struct packed {
    logic             first;
    logic             last;
    logic [ROW_W-1:0] row;
  } msg_tag_t;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} rd_state_e;

endpackage

// File: rtl/cn_msg_fifo2.sv
// Generic 2-entry valid/ready FIFO; head register drives the output directly.
module cn_msg_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign pop     = pop_i && (cnt_q != 2'd0);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = cnt_q;

  // Next-state: push/pop together keeps occupancy and order.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          head_d = data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop) begin
          head_d = data_i;
        end else if (push_i) begin
          tail_d = data_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // A push with no pop here would overflow; the producer never does that.
        if (pop) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = data_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cn_msg_reader.sv
// Row-major read sequencer for the edge-message SRAM feeding the check-node unit.
module cn_msg_reader
  import ldpc_pkg::*;
#(
  parameter int unsigned ROW_NUMBER = ldpc_pkg::ROW_NUMBER,
  parameter int unsigned ROW_WEIGHT = ldpc_pkg::ROW_WEIGHT,
  parameter int unsigned WIDTH      = ldpc_pkg::WIDTH,
  parameter int unsigned ADDR_W     = ldpc_pkg::ADDR_W,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_rreq,
  input  logic                            i_rgnt,
  output logic [ADDR_W-1:0]               o_raddr,
  input  logic [WIDTH-1:0]                i_rdata,
  output logic [WIDTH-1:0]                o_msg,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_first,
  output logic                            o_last,
  output logic [idx_w(ROW_NUMBER)-1:0]    o_row
);

  localparam int unsigned RowW  = idx_w(ROW_NUMBER);
  localparam int unsigned EdgeW = idx_w(ROW_WEIGHT);
  localparam int unsigned PayW  = WIDTH + 2 + RowW;
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(ROW_WEIGHT - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(ROW_NUMBER - 1);

  rd_state_e         state_q, state_d;
  logic [EdgeW-1:0]  k_q, k_d;
  logic [RowW-1:0]   r_q, r_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              infl_q;
  logic              tfirst_q, tfirst_d, tlast_q, tlast_d;
  logic [RowW-1:0]   trow_q, trow_d;

  logic [1:0]        occ, occ_left;
  logic              pop, issue, fifo_valid;
  logic [PayW-1:0]   fifo_in, fifo_out;

  assign pop      = fifo_valid && i_ready;
  assign occ_left = occ - {1'b0, pop};
  // Buffered plus in-flight never exceeds the two FIFO slots.
  assign o_rreq   = (state_q == StRun) && ((occ_left + {1'b0, infl_q}) < 2'd2);
  assign issue    = o_rreq && i_rgnt;

  assign o_raddr  = addr_q;
  assign o_busy   = (state_q != StIdle);
  assign o_done   = (state_q == StDone);
  assign o_valid  = fifo_valid;
  assign {o_msg, o_first, o_last, o_row} = fifo_out;

  // Read data lands one cycle after issue, joined with the tags captured at issue.
  assign fifo_in = {i_rdata, tfirst_q, tlast_q, trow_q};

  cn_msg_fifo2 #(
    .Width(PayW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (infl_q),
    .data_i (fifo_in),
    .pop_i  (pop),
    .valid_o(fifo_valid),
    .data_o (fifo_out),
    .count_o(occ)
  );

  // FSM next-state, edge/row counters and linear address pointer.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    addr_d   = addr_q;
    tfirst_d = tfirst_q;
    tlast_d  = tlast_q;
    trow_d   = trow_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
          k_d     = '0;
          r_d     = '0;
          addr_d  = ADDR_W'(BASE_ADDR);
        end
      end
      StRun: begin
        if (issue && (k_q == LastEdge) && (r_q == LastRow)) state_d = StDrain;
      end
      StDrain: begin
        if ((occ_left == 2'd0) && !infl_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (issue) begin
      tfirst_d = (k_q == '0);
      tlast_d  = (k_q == LastEdge);
      trow_d   = r_q;
      addr_d   = addr_q + 1'b1;
      if (k_q == LastEdge) begin
        k_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      r_q      <= '0;
      addr_q   <= '0;
      infl_q   <= 1'b0;
      tfirst_q <= 1'b0;
      tlast_q  <= 1'b0;
      trow_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      r_q      <= r_d;
      addr_q   <= addr_d;
      infl_q   <= issue;
      tfirst_q <= tfirst_d;
      tlast_q  <= tlast_d;
      trow_q   <= trow_d;
    end
  end

endmodule

// File: tb/tb_cn_msg_reader.sv
// Scoreboard bench for cn_msg_reader: small geometry instance plus an address-wrap instance.
module tb_cn_msg_reader;

  localparam int unsigned Base  = 16;
  localparam int unsigned NMsg  = 12;
  localparam int unsigned WBase = 32'h000F_FFFC;
  localparam int unsigned WMsg  = 512 * 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_start, i_rgnt, i_ready;
  logic        o_busy, o_done, o_rreq, o_valid, o_first, o_last;
  logic [19:0] o_raddr;
  logic [7:0]  i_rdata, o_msg;
  logic [1:0]  o_row;

  logic        w_start, w_rgnt, w_ready;
  logic        w_busy, w_done, w_rreq, w_valid, w_first, w_last;
  logic [19:0] w_raddr;
  logic [7:0]  w_rdata, w_msg;
  logic [8:0]  w_row;

  cn_msg_reader #(
    .ROW_NUMBER(3), .ROW_WEIGHT(4), .WIDTH(8), .ADDR_W(20), .BASE_ADDR(Base)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rreq(o_rreq), .i_rgnt(i_rgnt), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_msg(o_msg), .o_valid(o_valid), .i_ready(i_ready), .o_first(o_first),
    .o_last(o_last), .o_row(o_row)
  );

  cn_msg_reader #(
    .ROW_NUMBER(512), .ROW_WEIGHT(6), .WIDTH(8), .ADDR_W(20), .BASE_ADDR(WBase)
  ) dut_wrap (
    .clk(clk), .rst(rst), .i_start(w_start), .o_busy(w_busy), .o_done(w_done),
    .o_rreq(w_rreq), .i_rgnt(w_rgnt), .o_raddr(w_raddr), .i_rdata(w_rdata),
    .o_msg(w_msg), .o_valid(w_valid), .i_ready(w_ready), .o_first(w_first),
    .o_last(w_last), .o_row(w_row)
  );

  // SRAM models: mem[a] = a; garbage on cycles with no read issued.
  always @(posedge clk) begin
    if (o_rreq && i_rgnt) i_rdata <= o_raddr[7:0];
    else                  i_rdata <= 8'($urandom);
    if (w_rreq && w_rgnt) w_rdata <= w_raddr[7:0];
    else                  w_rdata <= 8'($urandom);
  end

  typedef struct {
    logic [7:0] msg;
    logic       first;
    logic       last;
    int         row;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] exp_addr_q[$];
  int checks = 0, errors = 0;
  int pass_issues = 0, pass_hs = 0, outstanding = 0, cyc = 0;
  int first_issue_cyc = 0, first_valid_cyc = 0, hs_first_cyc = 0, hs_last_cyc = 0;
  bit valid_seen = 0;
  int gate_cycles = 0;
  logic busy_m, done_due, stall_prev, fin;
  logic [11:0] held;
  exp_t e;
  int wn = 0, wm = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard for the main instance.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      busy_m = 0; done_due = 0; stall_prev = 0; outstanding = 0;
    end else begin
      fin = 0;
      check("busy", o_busy, busy_m);
      check("done", o_done, done_due);
      if (stall_prev) begin
        check("hold_valid", o_valid, 1);
        check("hold_head", {o_msg, o_first, o_last, o_row}, held);
      end
      if (o_valid && !valid_seen) begin
        valid_seen = 1;
        first_valid_cyc = cyc;
      end
      if (o_rreq && i_rgnt) begin
        if (pass_issues == 0) first_issue_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_read: got addr 0x%0h, expected no read", o_raddr);
        end else begin
          check("raddr", o_raddr, exp_addr_q.pop_front());
        end
        outstanding++;
        pass_issues++;
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_msg: got msg 0x%0h, expected none", o_msg);
        end else begin
          e = exp_q.pop_front();
          check("msg", o_msg, e.msg);
          check("first", o_first, e.first);
          check("last", o_last, e.last);
          check("row", o_row, 64'(e.row));
          fin = e.last && (e.row == 2);
        end
        if (pass_hs == 0) hs_first_cyc = cyc;
        hs_last_cyc = cyc;
        pass_hs++;
        outstanding--;
      end
      check("outstanding_le2", (outstanding <= 2), 1);
      busy_m     = (i_start && !busy_m) ? 1'b1 : (done_due ? 1'b0 : busy_m);
      done_due   = fin;
      stall_prev = o_valid && !i_ready;
      held       = {o_msg, o_first, o_last, o_row};
    end
  end

  // Monitor for the wrap instance: addresses advance modulo 2^20 from WBase.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_rreq && w_rgnt) begin
        check("wrap_raddr", w_raddr, 20'(WBase + wn));
        wn++;
      end
      if (w_valid && w_ready) begin
        check("wrap_msg", w_msg, 8'(WBase + wm));
        check("wrap_row", w_row, 64'(wm / 6));
        check("wrap_first", w_first, (wm % 6) == 0);
        check("wrap_last", w_last, (wm % 6) == 5);
        wm++;
      end
    end
  end

  // Push the expected pass, then pulse start for the current cycle.
  task automatic start_pass();
    exp_t x;
    for (int i = 0; i < int'(NMsg); i++) begin
      x.msg   = 8'(Base + i);
      x.first = (i % 4) == 0;
      x.last  = (i % 4) == 3;
      x.row   = i / 4;
      exp_q.push_back(x);
      exp_addr_q.push_back(20'(Base + i));
    end
    pass_issues = 0;
    pass_hs     = 0;
    valid_seen  = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Drive grant/ready per mode until o_done or the budget expires.
  task automatic run_pass(input int mode);
    int  gcnt = 0;
    bit  gused = 0;
    bit  hit = 0;
    for (int n = 0; n < 400; n++) begin
      case (mode)
        1: begin i_ready = (n % 4 == 0) || (n % 4 == 3); i_rgnt = 1'b1; end
        2: begin
          i_ready = 1'b1;
          if (!gused && pass_issues == 2) begin gcnt = 5; gused = 1; end
          i_rgnt = (gcnt == 0);
        end
        3: begin
          i_ready = ($urandom_range(0, 3) != 0);
          i_rgnt  = ($urandom_range(0, 3) != 0);
        end
        default: begin i_ready = 1'b1; i_rgnt = 1'b1; end
      endcase
      @(negedge clk);
      if (gcnt > 0) begin
        check("gnt_rreq_held", o_rreq, 1);
        check("gnt_addr_frozen", o_raddr, 20'(Base + 2));
        gate_cycles++;
        gcnt--;
      end
      if (o_done) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no o_done, expected o_done within 400 cycles");
    end
  endtask

  initial begin
    bit s1, s2, hit;
    rst = 1'b1; i_start = 1'b0; i_rgnt = 1'b0; i_ready = 1'b0;
    w_start = 1'b0; w_rgnt = 1'b1; w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_outputs", {o_busy, o_done, o_rreq, o_valid, o_first, o_last}, 6'b0);
    check("rst_raddr", o_raddr, 0);
    check("rst_row_msg", {o_row, o_msg}, 0);
    @(posedge clk); #1;

    // Full-rate pass.
    start_pass();
    run_pass(0);
    check("drained_full_rate", exp_q.size(), 0);
    check("first_valid_latency", first_valid_cyc - first_issue_cyc, 2);
    check("back_to_back_span", hs_last_cyc - hs_first_cyc, NMsg - 1);
    @(posedge clk); #1;

    // Downstream stalls 1,0,0,1.
    start_pass();
    run_pass(1);
    check("drained_stall", exp_q.size(), 0);
    @(posedge clk); #1;

    // Grant withdrawn for five cycles at the third read.
    gate_cycles = 0;
    start_pass();
    run_pass(2);
    check("drained_gnt", exp_q.size(), 0);
    check("gnt_window_len", gate_cycles, 5);
    @(posedge clk); #1;

    // Reset while the seventh read is pending.
    start_pass();
    i_ready = 1'b1; i_rgnt = 1'b1;
    for (int n = 0; n < 50 && pass_issues < 6; n++) begin
      @(posedge clk); #1;
    end
    check("reach_7th_read", pass_issues, 6);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_addr", o_raddr, 20'(Base + 6));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", o_valid, 0);
    check("post_rst_idle", {o_busy, o_rreq}, 2'b00);
    @(posedge clk); #1;
    start_pass();
    run_pass(0);
    check("drained_after_rst", exp_q.size(), 0);
    @(posedge clk); #1;

    // Starts during RUN and DONE are ignored; next cycle start works.
    start_pass();
    i_ready = 1'b1; i_rgnt = 1'b1;
    s1 = 0; s2 = 0; hit = 0;
    for (int n = 0; n < 200; n++) begin
      i_start = 1'b0;
      if (!s1 && pass_issues == 5) begin i_start = 1'b1; s1 = 1; end
      if (!s2 && pass_hs == int'(NMsg)) begin i_start = 1'b1; s2 = 1; end
      @(negedge clk);
      if (o_done) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    check("ignored_start_done_seen", hit, 1);
    check("start_during_done", {s1, s2}, 2'b11);
    check("drained_ignored_start", exp_q.size(), 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    start_pass();
    run_pass(0);
    check("drained_restart", exp_q.size(), 0);
    @(posedge clk); #1;

    // Random grant and ready.
    for (int p = 0; p < 3; p++) begin
      start_pass();
      run_pass(3);
      check("drained_random", exp_q.size(), 0);
      @(posedge clk); #1;
    end
    i_rgnt = 1'b0; i_ready = 1'b1;

    // Default geometry with the address pointer wrapping past 0xFFFFF.
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    hit = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (w_done) begin hit = 1; break; end
    end
    check("wrap_done", hit, 1);
    check("wrap_reads", wn, WMsg);
    check("wrap_msgs", wm, WMsg);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cn_msg_reader.md
Name: cn_msg_reader

Overview:
Read sequencer on the read port of the LDPC edge-message SRAM. On start it walks the message memory row-major, ROW_WEIGHT consecutive edge addresses per parity-check row, for rows 0..ROW_NUMBER-1. It absorbs the SRAM's one-cycle registered read latency and delivers a valid/ready message stream, tagged with row boundaries, to the downstream check-node update unit. A 2-entry output buffer provides backpressure tolerance.

Parameters:
ROW_NUMBER, 512, number of parity-check rows per pass
ROW_WEIGHT, 6, edges (messages) per row
WIDTH, 8, message width in bits; equals the SRAM data width
ADDR_W, 20, SRAM address width
BASE_ADDR, 0, address of edge 0 of row 0

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_start  in  1  start one pass; honoured only in IDLE
o_busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
o_done  out  1  one-cycle pulse after the last message is accepted downstream
o_rreq  out  1  read request to the arbiter; the top level holds the SRAM write enable low when granted
i_rgnt  in  1  read granted this cycle; a read issues only when o_rreq && i_rgnt
o_raddr  out  ADDR_W  SRAM read address, valid while o_rreq is high
i_rdata  in  WIDTH  SRAM read data, valid the cycle after an issued read
o_msg  out  WIDTH  message to the check-node unit
o_valid  out  1  o_msg and its tags are valid
i_ready  in  1  downstream accepts when o_valid && i_ready
o_first  out  1  message is edge 0 of its row
o_last  out  1  message is edge ROW_WEIGHT-1 of its row
o_row  out  clog2(ROW_NUMBER)  row index of the message

Behaviour:
- Reset: FSM goes to IDLE; buffer is emptied; in-flight flag is cleared. o_busy, o_done, o_rreq, o_valid, o_first and o_last are 0. o_raddr, o_row and o_msg are 0. Reset mid-pass abandons the pass; read data returning after reset is discarded.
- FSM states:
  - IDLE -> RUN on i_start.
  - RUN -> DRAIN in the cycle the read of the final edge issues.
  - DRAIN -> DONE when the buffer is empty, no read is in flight, and no handshake is pending.
  - DONE -> IDLE after one cycle. o_done = 1 only in DONE.
- i_start in RUN, DRAIN or DONE is ignored; no queueing.
- Counters: edge counter k in 0..ROW_WEIGHT-1 and row counter r in 0..ROW_NUMBER-1 are cleared on accepted start. Both advance on each issued read: k wraps to 0 and r increments at k = ROW_WEIGHT-1.
- Address: o_raddr = BASE_ADDR + r*ROW_WEIGHT + k. It is computed as a running linear pointer incremented per issued read, with no multiplier, truncated to ADDR_W.
- o_rreq = (state == RUN) && (buffer occupancy + in-flight < 2). Occupancy is counted after this cycle's pop.
- Read latency: a read issued in cycle t places i_rdata in the buffer at the end of t+1. Tags (first = k==0, last = k==ROW_WEIGHT-1, row r) are registered at issue and travel alongside the data.
- Output buffer: 2-entry FIFO holding {msg, first, last, row}. o_valid = not empty. Head is stable while o_valid && !i_ready.
- Simultaneous push and pop: occupancy unchanged and ordering preserved. Overflow is impossible by construction; the bench asserts it never occurs.
- Throughput: with i_rgnt = 1 and i_ready = 1 held, one message per cycle. The first o_valid appears 2 cycles after the first issued read.
- Grant withdrawn: the address and counters hold, o_rreq stays high, and no read is issued.
- o_done asserts exactly one cycle after the handshake of the final message (row ROW_NUMBER-1, o_last).

Decomposition:
- Shared package ldpc_pkg holds ROW_NUMBER, ROW_WEIGHT, WIDTH, ADDR_W, a row-index width function, and a msg_tag_t struct {first, last, row}.
- One sub-module, cn_msg_fifo2: a generic 2-entry valid/ready FIFO parameterised on payload width, reusable by the downstream write-back sequencer.

Test Plan:
- Overrides ROW_NUMBER=3, ROW_WEIGHT=4, BASE_ADDR=16; i_rgnt=1, i_ready=1; SRAM model mem[a]=a; one start pulse -> addresses 16..27 in order, o_msg 16..27 on consecutive cycles. o_first on 16/20/24, o_last on 19/23/27, o_row 0,0,0,0,1,...,2. o_done one cycle after message 27; o_busy covers exactly that span.
- Same config, i_ready toggling 1,0,0,1 repeating -> no message lost or duplicated. o_msg holds while stalled; at most 2 reads outstanding or buffered at any time.
- i_rgnt low for 5 cycles starting at the 3rd read -> o_raddr frozen at 18 with o_rreq high. The sequence resumes at 18; output stream identical to the first test.
- Reset asserted while reading the 7th edge (address 22) with one read in flight -> o_valid=0 next cycle and FSM in IDLE. A following start re-reads from address 16 with no stale data emitted.
- i_start pulsed again during RUN and during DONE -> ignored: exactly 12 messages and one o_done. A start in the cycle after DONE begins a new pass.
- Default parameters, BASE_ADDR=2^20-4 -> address wraps to 0 after 0xFFFFF, modulo 2^ADDR_W.
